// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the SRAM load/store controller.
//   state_t      : controller FSM states
//   req_t        : request fields latched when an access starts
//   word_offset  : byte address -> word offset relative to a base address
package sram_controller_pkg;

   localparam int unsigned DEFAULT_BASE_ADDR   = 1024;
   localparam int unsigned DEFAULT_WAIT_CYCLES = 5;
   localparam int unsigned DEFAULT_SRAM_AW     = 18;
   localparam int unsigned CNT_W               = 4;
   localparam int unsigned DATA_W              = 32;
   localparam int unsigned HALF_W              = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Only the high half of the store data must be kept; the low half goes
   // straight into the bus output register when the access starts.
   typedef struct packed {
      logic              write;
      logic [HALF_W-1:0] hi_data;
   } req_t;

   function automatic logic [DATA_W-1:0] word_offset(input logic [DATA_W-1:0] addr,
                                                     input logic [DATA_W-1:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side load/store bus of the SRAM controller.
//   rdEn, wrEn  : load / store request from the MEM stage
//   address     : byte address (ALU result)
//   writeData   : store data (forwarded Rm)
//   readData    : load result
//   ready       : 0 freezes the pipeline
// master = MEM stage, slave = controller.
interface sram_controller_if;

   logic        rdEn;
   logic        wrEn;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ready;

   modport master (output rdEn, wrEn, address, writeData,
                   input  readData, ready);

   modport slave  (input  rdEn, wrEn, address, writeData,
                   output readData, ready);

endinterface

// File: rtl/sram_controller_wait_counter.sv
// Wait-state counter for one half-word access.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (takes priority over counting)
//   tc       : count has reached WAIT_CYCLES
module sram_controller_wait_counter
   import sram_controller_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tc
);

   logic [CNT_W-1:0] count;

   // Counts up every cycle unless cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// Serialises 32-bit load/store requests into two 16-bit accesses on an
// asynchronous SRAM with programmable wait states; holds ready low while busy.
//   clk, rst   : clock, async active-high reset
//   bus        : pipeline-side request/response (slave modport)
//   sramDq     : SRAM data bus, driven only while sramWeN is low
//   sramAddr   : SRAM half-word address
//   sramWeN    : SRAM write enable, active low
//   sramCeN, sramOeN, sramUbN, sramLbN : tied active
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
   parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
   input  logic               clk,
   input  logic               rst,
   sram_controller_if.slave   bus,
   inout  wire  [15:0]        sramDq,
   output logic [SRAM_AW-1:0] sramAddr,
   output logic               sramWeN,
   output logic               sramCeN,
   output logic               sramOeN,
   output logic               sramUbN,
   output logic               sramLbN
);

   localparam int unsigned IDX_W = SRAM_AW - 1;

   state_t            state;
   state_t            state_next;
   req_t              req_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_c;
   logic [HALF_W-1:0] dq_out;
   logic              req_c;
   logic              ready_c;
   logic              cnt_clr_c;
   logic              tc;

   assign req_c = bus.rdEn | bus.wrEn;
   assign idx_c = IDX_W'(word_offset(bus.address, DATA_W'(BASE_ADDR)));

   assign sramCeN = 1'b0;
   assign sramOeN = 1'b0;
   assign sramUbN = 1'b0;
   assign sramLbN = 1'b0;

   // Bus is released whenever no write strobe is active.
   assign sramDq = sramWeN ? {HALF_W{1'bz}} : dq_out;

   assign bus.ready = ready_c;

   sram_controller_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr_c),
      .tc  (tc)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, ready and counter control.
   always_comb begin
      state_next = state;
      ready_c    = 1'b0;
      cnt_clr_c  = 1'b1;
      unique case (state)
         ST_IDLE: begin
            ready_c = ~req_c;
            if (req_c) begin
               state_next = ST_LOW;
            end
         end
         ST_LOW: begin
            cnt_clr_c = tc;
            if (tc) begin
               state_next = ST_HIGH;
            end
         end
         ST_HIGH: begin
            cnt_clr_c = tc;
            if (tc) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            ready_c    = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Request latch, SRAM pins and read capture; pin registers are loaded with
   // the values for the state being entered so they line up with the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q        <= '0;
         idx_q        <= '0;
         dq_out       <= '0;
         sramAddr     <= '0;
         sramWeN      <= 1'b1;
         bus.readData <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_c) begin
                  req_q.write   <= bus.wrEn;
                  req_q.hi_data <= bus.writeData[31:16];
                  idx_q         <= idx_c;
                  sramAddr      <= {idx_c, 1'b0};
                  dq_out        <= bus.writeData[15:0];
                  sramWeN       <= ~bus.wrEn;
               end
            end
            ST_LOW: begin
               if (tc) begin
                  sramAddr <= {idx_q, 1'b1};
                  dq_out   <= req_q.hi_data;
                  // Strobe is lifted while the address moves to the high half;
                  // with no wait states there is no later cycle to write in.
                  sramWeN  <= (WAIT_CYCLES == 0) ? ~req_q.write : 1'b1;
                  if (!req_q.write) begin
                     bus.readData[15:0] <= sramDq;
                  end
               end
            end
            ST_HIGH: begin
               if (tc) begin
                  sramWeN <= 1'b1;
                  if (!req_q.write) begin
                     bus.readData[31:16] <= sramDq;
                  end
               end else begin
                  sramWeN <= ~req_q.write;
               end
            end
            default: sramWeN <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (5 and 0 wait states), each with a
// behavioural async SRAM; a scoreboard queue per instance is checked by a
// monitor whenever ready rises after a busy period.
module tb_sram_controller;

   typedef struct {
      logic [31:0] rd;
      int unsigned lat;
      logic        chk;
      logic [7:0]  ma;
      logic [31:0] mv;
   } exp_t;

   localparam int unsigned LAT_A = 13;
   localparam int unsigned LAT_B = 3;

   logic clk = 1'b0;
   logic rst_a, rst_b, mem_init;

   sram_controller_if bus_a ();
   sram_controller_if bus_b ();

   wire  [15:0] dq_a, dq_b;
   logic [17:0] addr_a, addr_b;
   logic        we_n_a, we_n_b;
   logic        ce_n_a, oe_n_a, ub_n_a, lb_n_a;
   logic        ce_n_b, oe_n_b, ub_n_b, lb_n_b;

   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];

   exp_t q_a[$];
   exp_t q_b[$];
   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   logic        busy_a = 1'b0, busy_b = 1'b0;
   int unsigned lowc_a = 0, lowc_b = 0;

   always #5 clk = ~clk;

   sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(5), .SRAM_AW(18)) dut_a (
      .clk(clk), .rst(rst_a), .bus(bus_a), .sramDq(dq_a), .sramAddr(addr_a),
      .sramWeN(we_n_a), .sramCeN(ce_n_a), .sramOeN(oe_n_a), .sramUbN(ub_n_a), .sramLbN(lb_n_a));

   sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0), .SRAM_AW(18)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b), .sramDq(dq_b), .sramAddr(addr_b),
      .sramWeN(we_n_b), .sramCeN(ce_n_b), .sramOeN(oe_n_b), .sramUbN(ub_n_b), .sramLbN(lb_n_b));

   // Async SRAM models: output enabled whenever not being written.
   assign dq_a = we_n_a ? mem_a[addr_a[7:0]] : 16'bz;
   assign dq_b = we_n_b ? mem_b[addr_b[7:0]] : 16'bz;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) begin
            mem_a[i] <= 16'hC000 + 16'(i);
            mem_b[i] <= 16'hC000 + 16'(i);
         end
      end else begin
         if (!we_n_a) mem_a[addr_a[7:0]] <= dq_a;
         if (!we_n_b) mem_b[addr_b[7:0]] <= dq_b;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%h, want 0x%h", nm, act, req);
   endtask

   function automatic exp_t mk(input logic [31:0] rd, input int unsigned lat,
                               input logic chk, input logic [7:0] ma, input logic [31:0] mv);
      exp_t e;
      e.rd = rd; e.lat = lat; e.chk = chk; e.ma = ma; e.mv = mv;
      return e;
   endfunction

   task automatic complete(input int k, input int unsigned lat, input logic [31:0] rd);
      exp_t e;
      logic [15:0] lo, hi;
      if ((k == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
         check("spurious_done", 32'd1, 32'd0);
         return;
      end
      e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
      check("readData", rd, e.rd);
      check("latency", 32'(lat), 32'(e.lat));
      if (e.chk) begin
         lo = (k == 0) ? mem_a[e.ma] : mem_b[e.ma];
         hi = (k == 0) ? mem_a[e.ma + 8'd1] : mem_b[e.ma + 8'd1];
         check("mem_lo", 32'(lo), 32'(e.mv[15:0]));
         check("mem_hi", 32'(hi), 32'(e.mv[31:16]));
      end
   endtask

   // Monitors: count ready-low cycles, score each busy period when ready rises.
   always @(negedge clk) begin
      if (rst_a) begin
         busy_a = 1'b0; lowc_a = 0;
      end else if (!bus_a.ready) begin
         busy_a = 1'b1; lowc_a++;
      end else if (busy_a) begin
         complete(0, lowc_a, bus_a.readData);
         busy_a = 1'b0; lowc_a = 0;
      end
   end

   always @(negedge clk) begin
      if (rst_b) begin
         busy_b = 1'b0; lowc_b = 0;
      end else if (!bus_b.ready) begin
         busy_b = 1'b1; lowc_b++;
      end else if (busy_b) begin
         complete(1, lowc_b, bus_b.readData);
         busy_b = 1'b0; lowc_b = 0;
      end
   end

   task automatic drive(input int k, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (k == 0) begin
         bus_a.rdEn = rd; bus_a.wrEn = wr; bus_a.address = a; bus_a.writeData = d;
      end else begin
         bus_b.rdEn = rd; bus_b.wrEn = wr; bus_b.address = a; bus_b.writeData = d;
      end
   endtask

   task automatic wait_ready(input int k);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if ((k == 0) ? bus_a.ready : bus_b.ready) return;
      end
      check("ready_timeout", 32'd0, 32'd1);
   endtask

   // Issue a request, hold it (frozen pipeline) until ready is seen high.
   task automatic access(input int k, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input exp_t e);
      @(posedge clk); #1;
      drive(k, rd, wr, a, d);
      if (k == 0) q_a.push_back(e); else q_b.push_back(e);
      wait_ready(k);
   endtask

   task automatic idle(input int k);
      @(posedge clk); #1;
      drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; mem_init = 1'b1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_a = 1'b0; rst_b = 1'b0; mem_init = 1'b0;

      // Reset / idle state.
      @(negedge clk);
      check("rst_ready", 32'(bus_a.ready), 32'd1);
      check("rst_we_n", 32'(we_n_a), 32'd1);
      check("rst_readData", bus_a.readData, 32'd0);
      check("rst_addr", 32'(addr_a), 32'd0);
      check("rst_bus_released", 32'(dq_a), 32'h0000C000);
      check("tie_offs", 32'({ce_n_a, oe_n_a, ub_n_a, lb_n_a, ce_n_b, oe_n_b, ub_n_b, lb_n_b}), 32'd0);
      check("rst_ready_b", 32'(bus_b.ready), 32'd1);

      // Store then load at the base address.
      access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, mk(32'd0, LAT_A, 1'b1, 8'd0, 32'hDEADBEEF));
      access(0, 1'b1, 1'b0, 32'd1024, 32'd0, mk(32'hDEADBEEF, LAT_A, 1'b0, 8'd0, 32'd0));

      // Back-to-back store/load at word 2; request held through DONE each time.
      access(0, 1'b0, 1'b1, 32'd1032, 32'h12345678, mk(32'hDEADBEEF, LAT_A, 1'b1, 8'd4, 32'h12345678));
      access(0, 1'b1, 1'b0, 32'd1032, 32'd0, mk(32'h12345678, LAT_A, 1'b0, 8'd0, 32'd0));

      // Both enables: a write, readData untouched.
      access(0, 1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, mk(32'h12345678, LAT_A, 1'b1, 8'd2, 32'hA5A55A5A));

      // Inputs changed mid-access are ignored: still a load of word 0.
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'd1024, 32'd0);
      q_a.push_back(mk(32'hDEADBEEF, LAT_A, 1'b0, 8'd0, 32'd0));
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 32'd1028, 32'h0);
      wait_ready(0);
      idle(0);

      // Write to word 3, strobe timing around the half switch, then reset in HIGH cycle 3.
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c == 0) check("req_ready_low", 32'(bus_a.ready), 32'd0);
         if (c == 6) begin
            check("low_last_we_n", 32'(we_n_a), 32'd0);
            check("low_addr", 32'(addr_a), 32'd6);
         end
         if (c == 7) begin
            check("high_first_we_n", 32'(we_n_a), 32'd1);
            check("high_addr", 32'(addr_a), 32'd7);
            check("high_ready", 32'(bus_a.ready), 32'd0);
         end
         if (c == 8) check("high_second_we_n", 32'(we_n_a), 32'd0);
      end
      @(posedge clk); #1;
      rst_a = 1'b1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check("abort_ready", 32'(bus_a.ready), 32'd1);
      check("abort_we_n", 32'(we_n_a), 32'd1);
      check("abort_bus_released", 32'(dq_a), 32'h0000BEEF);
      check("abort_readData", bus_a.readData, 32'd0);
      check("abort_partial_lo", 32'(mem_a[6]), 32'h0000F00D);
      check("abort_partial_hi", 32'(mem_a[7]), 32'h0000CAFE);
      @(posedge clk); #1 rst_a = 1'b0;

      // Clean access after the abort.
      access(0, 1'b1, 1'b0, 32'd1028, 32'd0, mk(32'hA5A55A5A, LAT_A, 1'b0, 8'd0, 32'd0));
      idle(0);

      // Zero wait states: preloaded read, then a write.
      access(1, 1'b1, 1'b0, 32'd1024, 32'd0, mk(32'hC001C000, LAT_B, 1'b0, 8'd0, 32'd0));
      access(1, 1'b0, 1'b1, 32'd1028, 32'h0BADCAFE, mk(32'hC001C000, LAT_B, 1'b0, 8'd0, 32'd0));
      idle(1);

      repeat (5) @(posedge clk);
      check("queue_a_drained", 32'(q_a.size()), 32'd0);
      check("queue_b_drained", 32'(q_b.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
